// File: rtl/accel_cmd_arbiter_pkg.sv
// Shared widths, command/response field offsets and FSM encoding for the
// two-requester accelerator command arbiter.
package accel_pkg;

  localparam int CMD_W  = 160;
  localparam int RESP_W = 74;
  localparam int XD_BIT = 17;

  // Command field offsets (RoCC-style instruction word plus operand data)
  localparam int CMD_FUNCT_LSB    = 0;
  localparam int CMD_RS2_LSB      = 7;
  localparam int CMD_RS1_LSB      = 12;
  localparam int CMD_XS1_BIT      = 18;
  localparam int CMD_XS2_BIT      = 19;
  localparam int CMD_RD_LSB       = 20;
  localparam int CMD_OPCODE_LSB   = 25;
  localparam int CMD_RS1_DATA_LSB = 32;
  localparam int CMD_RS2_DATA_LSB = 96;

  // Response field offsets
  localparam int RESP_STATUS_LSB = 0;
  localparam int RESP_RD_LSB     = 5;
  localparam int RESP_DATA_LSB   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  function automatic req_id_e other_req(input req_id_e r);
    return (r == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/accel_cmd_arbiter_if.sv
// Bundle of requester-side and accelerator-side handshakes around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface accel_cmd_arbiter_if #(
  parameter int CMD_W  = accel_pkg::CMD_W,
  parameter int RESP_W = accel_pkg::RESP_W
);

  logic [CMD_W-1:0]  cmd0;
  logic              cmd0_vld;
  logic              cmd0_rdy;
  logic [CMD_W-1:0]  cmd1;
  logic              cmd1_vld;
  logic              cmd1_rdy;

  logic [RESP_W-1:0] resp0;
  logic              resp0_vld;
  logic              resp0_rdy;
  logic [RESP_W-1:0] resp1;
  logic              resp1_vld;
  logic              resp1_rdy;

  logic [CMD_W-1:0]  acc_cmd;
  logic              acc_cmd_vld;
  logic              acc_cmd_rdy;
  logic [RESP_W-1:0] acc_resp;
  logic              acc_resp_vld;
  logic              acc_resp_rdy;

  logic              busy;

  modport slave (
    input  cmd0, cmd0_vld, cmd1, cmd1_vld,
    input  resp0_rdy, resp1_rdy,
    input  acc_cmd_rdy, acc_resp, acc_resp_vld,
    output cmd0_rdy, cmd1_rdy,
    output resp0, resp0_vld, resp1, resp1_vld,
    output acc_cmd, acc_cmd_vld, acc_resp_rdy,
    output busy
  );

  modport master (
    output cmd0, cmd0_vld, cmd1, cmd1_vld,
    output resp0_rdy, resp1_rdy,
    output acc_cmd_rdy, acc_resp, acc_resp_vld,
    input  cmd0_rdy, cmd1_rdy,
    input  resp0, resp0_vld, resp1, resp1_vld,
    input  acc_cmd, acc_cmd_vld, acc_resp_rdy,
    input  busy
  );

endinterface

// File: rtl/accel_cmd_arbiter_rr_pick2.sv
// Combinational two-way pick: a lone valid requester wins, a tie goes to prio.
// Grants are one-hot or zero.
module accel_rr_pick2 (
  input  logic vld0,
  input  logic vld1,
  input  logic prio,
  output logic gnt0,
  output logic gnt1
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (vld0 && vld1) begin
      gnt0 = ~prio;
      gnt1 = prio;
    end else begin
      gnt0 = vld0;
      gnt1 = vld1;
    end
  end

endmodule

// File: rtl/accel_cmd_arbiter.sv
// Round-robin front end for one accelerator: registers the winning command,
// keeps one command in flight and steers the response back to its owner.
module accel_cmd_arbiter
  import accel_pkg::*;
#(
  parameter int CMD_W  = accel_pkg::CMD_W,
  parameter int RESP_W = accel_pkg::RESP_W,
  parameter int XD_BIT = accel_pkg::XD_BIT
) (
  input  logic                clk,
  input  logic                rst,
  accel_cmd_arbiter_if.slave  bus
);

  arb_state_e        state_q, state_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  req_id_e           owner_q, owner_d;
  req_id_e           prio_q, prio_d;
  logic              xd_q, xd_d;

  logic              gnt0, gnt1;
  logic              owner_resp_rdy;
  logic              cmd0_rdy_c, cmd1_rdy_c;
  logic              acc_cmd_vld_c, acc_resp_rdy_c;
  logic              resp0_vld_c, resp1_vld_c;

  accel_rr_pick2 u_pick (
    .vld0 (bus.cmd0_vld),
    .vld1 (bus.cmd1_vld),
    .prio (prio_q == REQ1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      owner_q <= REQ0;
      prio_q  <= REQ0;
      xd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      xd_q    <= xd_d;
    end
  end

  assign owner_resp_rdy = (owner_q == REQ1) ? bus.resp1_rdy : bus.resp0_rdy;

  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    owner_d        = owner_q;
    prio_d         = prio_q;
    xd_d           = xd_q;
    cmd0_rdy_c     = 1'b0;
    cmd1_rdy_c     = 1'b0;
    acc_cmd_vld_c  = 1'b0;
    acc_resp_rdy_c = 1'b0;
    resp0_vld_c    = 1'b0;
    resp1_vld_c    = 1'b0;

    case (state_q)
      IDLE: begin
        // A grant implies the matching vld, so the grant itself is the handshake
        cmd0_rdy_c = gnt0;
        cmd1_rdy_c = gnt1;
        if (gnt0) begin
          cmd_d   = bus.cmd0;
          owner_d = REQ0;
          xd_d    = bus.cmd0[XD_BIT];
          state_d = ISSUE;
        end else if (gnt1) begin
          cmd_d   = bus.cmd1;
          owner_d = REQ1;
          xd_d    = bus.cmd1[XD_BIT];
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        acc_cmd_vld_c = 1'b1;
        if (bus.acc_cmd_rdy) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        // Commands without a destination register have their response sunk here
        if (xd_q) begin
          acc_resp_rdy_c = owner_resp_rdy;
          resp0_vld_c    = bus.acc_resp_vld && (owner_q == REQ0);
          resp1_vld_c    = bus.acc_resp_vld && (owner_q == REQ1);
        end else begin
          acc_resp_rdy_c = 1'b1;
        end
        if (bus.acc_resp_vld && acc_resp_rdy_c) begin
          prio_d  = other_req(owner_q);
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cmd0_rdy     = cmd0_rdy_c;
  assign bus.cmd1_rdy     = cmd1_rdy_c;
  assign bus.acc_cmd      = cmd_q;
  assign bus.acc_cmd_vld  = acc_cmd_vld_c;
  assign bus.acc_resp_rdy = acc_resp_rdy_c;
  assign bus.resp0        = bus.acc_resp;
  assign bus.resp1        = bus.acc_resp;
  assign bus.resp0_vld    = resp0_vld_c;
  assign bus.resp1_vld    = resp1_vld_c;
  assign bus.busy         = (state_q != IDLE);

endmodule
